// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush wipes all; two read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_set_v,
  input  logic [ADDR_W-1:0] i_set_a,
  input  logic              i_clr_v,
  input  logic [ADDR_W-1:0] i_clr_a,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic              o_bsy1,
  output logic              o_bsy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // NOTE: always_comb uses blocking '=' with a default first, so later lines
  // override earlier ones (issue beats writeback) and no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_v) w_busy_nxt[i_clr_a] = 1'b0;
    if (i_set_v) w_busy_nxt[i_set_a] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_bsy1 = r_busy[i_ra1];
  assign o_bsy2 = r_busy[i_ra2];

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and sequential clear engine.
// Optional same-cycle write bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_v,
  input  logic [ADDR_W-1:0] iss_a,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              bsy1,
  output logic              bsy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_ready, w_wr_en, w_iss_en, w_sb_bsy1, w_sb_bsy2, w_hit1, w_hit2;

  assign w_ready  = (r_state == READY);
  assign w_wr_en  = w_ready && we && (wa != '0);
  assign w_iss_en = w_ready && iss_v && (iss_a != '0);
  assign ready    = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (flush) begin
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == ADDR_W'(DEPTH - 1)) r_state <= READY;
          end
        end
        READY: begin
          if (flush) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset; the clear engine zeroes it one entry per
  // cycle and reads are forced to zero until that sweep has finished.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) r_mem[r_clr_idx] <= '0;
    else if (w_wr_en)     r_mem[wa]        <= wd;
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_set_v (w_iss_en),
    .i_set_a (iss_a),
    .i_clr_v (w_wr_en),
    .i_clr_a (wa),
    .i_ra1   (ra1),
    .i_ra2   (ra2),
    .o_bsy1  (w_sb_bsy1),
    .o_bsy2  (w_sb_bsy2)
  );

`ifdef REGFILE_BYPASS_EN
  assign w_hit1 = w_wr_en && (wa == ra1);
  assign w_hit2 = w_wr_en && (wa == ra2);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  // A bypassed read sees the writeback value; its busy bit is only set if a
  // new producer issues to the same register in this cycle.
  always_comb begin
    rd1  = '0;
    rd2  = '0;
    bsy1 = 1'b0;
    bsy2 = 1'b0;
    if (w_ready) begin
      if (w_hit1)            rd1 = wd;
      else if (ra1 != '0)    rd1 = r_mem[ra1];
      if (w_hit2)            rd2 = wd;
      else if (ra2 != '0)    rd2 = r_mem[ra2];
      bsy1 = w_hit1 ? (w_iss_en && (iss_a == ra1)) : w_sb_bsy1;
      bsy2 = w_hit2 ? (w_iss_en && (iss_a == ra2)) : w_sb_bsy2;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array-level reference model.
// Same-cycle expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n, flush, we, iss_v;
  logic [4:0]  wa, iss_a, ra1, ra2;
  logic [31:0] wd, rd1, rd2;
  logic        bsy1, bsy2, ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_busy [DEPTH];
  bit          m_ready;
  int          m_clr_left;

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .bsy1(bsy1), .bsy2(bsy2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_ready    = 1'b0;
    m_clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the current inputs, then the DUT.
  task automatic step();
    if (!m_ready) begin
      if (flush) m_clr_left = DEPTH;
      else begin
        m_clr_left--;
        if (m_clr_left == 0) m_ready = 1'b1;
      end
    end else if (flush) begin
      model_reset();
    end else begin
      if (we && wa != 0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (iss_v && iss_a != 0) m_busy[iss_a] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (!m_ready || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return m_mem[ra];
  endfunction

  function automatic logic exp_bsy(input logic [4:0] ra);
    if (!m_ready || ra == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra) return iss_v && (iss_a == ra);
`endif
    return m_busy[ra];
  endfunction

  task automatic idle_inputs();
    flush = 0; we = 0; iss_v = 0; wa = 0; iss_a = 0; wd = 0; ra1 = 0; ra2 = 0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    ra1 = 5; ra2 = 7;
    #1;
    checks++;
    if (ready !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0 || bsy1 !== 1'b0 || bsy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rd1=%h rd2=%h bsy=%b%b exp all zero", ready, rd1, rd2, bsy1, bsy2);
    end
    #20;
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      we = 1; wa = 5'($urandom_range(1, 31)); wd = $urandom; iss_v = 1; iss_a = wa;
      ra1 = 5'($urandom); ra2 = wa;
      step();
      n++;
      if (!ready) begin
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || bsy1 !== 1'b0 || bsy2 !== 1'b0) begin
          errors++;
          $display("FAIL reset_clear_reads cyc=%0d rd1=%h rd2=%h bsy=%b%b exp 0", n, rd1, rd2, bsy1, bsy2);
        end
      end
    end
    idle_inputs();
    checks++;
    if (n != DEPTH || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_latency ready_after=%0d exp=%0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = 5'(i); ra2 = 5'(DEPTH - 1 - i);
      #1;
      checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0 || bsy1 !== 1'b0 || bsy2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_cleared ra1=%0d rd1=%h rd2=%h bsy=%b%b exp 0", i, rd1, rd2, bsy1, bsy2);
      end
    end
  endtask

  task automatic test_write();
    we = 1; wa = 5; wd = 32'hDEADBEEF; ra1 = 5; ra2 = 0;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_bypass rd1=%h exp=%h", rd1, 32'hDEADBEEF);
    end
`endif
    step();
    we = 0;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL write_next rd1=%h rd2=%h exp=%h/0", rd1, rd2, 32'hDEADBEEF);
    end
  endtask

  task automatic test_addr0();
    we = 1; wa = 0; wd = 32'h1234; iss_v = 1; iss_a = 0; ra1 = 0; ra2 = 0;
    step();
    idle_inputs();
    #1;
    checks++;
    if (rd1 !== 32'h0 || bsy1 !== 1'b0) begin
      errors++;
      $display("FAIL addr0 rd1=%h bsy1=%b exp 0/0", rd1, bsy1);
    end
  endtask

  task automatic test_scoreboard();
    iss_v = 1; iss_a = 7; ra1 = 7; ra2 = 6;
    step();
    iss_v = 0;
    #1;
    checks++;
    if (bsy1 !== 1'b1 || bsy2 !== 1'b0) begin
      errors++;
      $display("FAIL sb_issue bsy1=%b bsy2=%b exp 1/0", bsy1, bsy2);
    end
    we = 1; wa = 7; wd = 32'h1111_2222;
    step();
    we = 0;
    #1;
    checks++;
    if (bsy1 !== 1'b0 || rd1 !== 32'h1111_2222) begin
      errors++;
      $display("FAIL sb_writeback bsy1=%b rd1=%h exp 0/%h", bsy1, rd1, 32'h1111_2222);
    end
    we = 1; wa = 7; wd = 32'h3333_4444; iss_v = 1; iss_a = 7;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (bsy1 !== 1'b1 || rd1 !== 32'h3333_4444) begin
      errors++;
      $display("FAIL sb_same_bypass bsy1=%b rd1=%h exp 1/%h", bsy1, rd1, 32'h3333_4444);
    end
`endif
    step();
    we = 0; iss_v = 0;
    #1;
    checks++;
    if (bsy1 !== 1'b1 || rd1 !== 32'h3333_4444) begin
      errors++;
      $display("FAIL sb_same_cycle bsy1=%b rd1=%h exp 1/%h", bsy1, rd1, 32'h3333_4444);
    end
  endtask

  task automatic test_flush();
    int n;
    we = 1; wa = 3; wd = 32'hA5A5A5A5; iss_v = 1; iss_a = 9;
    step();
    idle_inputs();
    ra1 = 3; ra2 = 9;
    #1;
    checks++;
    if (rd1 !== 32'hA5A5A5A5 || bsy2 !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre rd1=%h bsy2=%b exp %h/1", rd1, bsy2, 32'hA5A5A5A5);
    end
    flush = 1;
    step();
    flush = 0;
    n = 0;
    while (!ready && n < 40) begin
      we = 1; wa = 3; wd = 32'hFFFF_FFFF; iss_v = 1; iss_a = 3;
      step();
      n++;
      if (!ready) begin
        checks++;
        if (rd1 !== 32'h0 || bsy1 !== 1'b0 || bsy2 !== 1'b0) begin
          errors++;
          $display("FAIL flush_clear_reads cyc=%0d rd1=%h bsy=%b%b exp 0", n, rd1, bsy1, bsy2);
        end
      end
    end
    idle_inputs();
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL flush_latency ready_after=%0d exp=%0d", n, DEPTH);
    end
    ra1 = 3;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL flush_r3 rd1=%h exp 0", rd1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      checks++;
      if (bsy1 !== 1'b0 || bsy2 !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy reg=%0d bsy=%b%b exp 0", i, bsy1, bsy2);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midclear_reset ready=%b exp 0", ready);
    end
    #19;
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL midclear_latency ready_after=%0d exp=%0d", n, DEPTH);
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 199) == 0);
      we    = 1'($urandom);
      wa    = rnd_addr();
      wd    = $urandom;
      iss_v = 1'($urandom);
      iss_a = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      ra1   = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      ra2   = rnd_addr();
      #1;
      checks++;
      if (ready !== m_ready || rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2) ||
          bsy1 !== exp_bsy(ra1) || bsy2 !== exp_bsy(ra2)) begin
        errors++;
        $display("FAIL random c=%0d ready=%b/%b ra1=%0d rd1=%h/%h bsy1=%b/%b ra2=%0d rd2=%h/%h bsy2=%b/%b",
                 c, ready, m_ready, ra1, rd1, exp_rd(ra1), bsy1, exp_bsy(ra1),
                 ra2, rd2, exp_rd(ra2), bsy2, exp_bsy(ra2));
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_write();
    test_addr0();
    test_scoreboard();
    test_flush();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with scoreboard for the pipelined CPU datapath; successor to the fixed 32×32 register file. Two asynchronous read ports and one synchronous write port over a configurable-width/depth array, register 0 hardwired to zero, a per-register busy scoreboard for hazard detection, and a sequential clear engine that zeroes the array after reset or on flush. Sits between decode (read/issue) and writeback.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous request to re-clear array and scoreboard
- ready  output  1  high when clear engine idle and ports active
- we  input  1  writeback enable
- wa  input  ADDR_W  writeback address
- wd  input  DATA_W  writeback data
- iss_v  input  1  issue: mark destination busy
- iss_a  input  ADDR_W  issue destination address
- ra1, ra2  input  ADDR_W  read addresses
- rd1, rd2  output  DATA_W  read data
- bsy1, bsy2  output  1  busy flag of ra1/ra2

## Operation
- FSM states: CLEAR, READY. rst_n low → CLEAR asynchronously, clr_idx=0, all busy bits 0.
- CLEAR: each cycle writes 0 to state[clr_idx], clr_idx++; after entry DEPTH-1 is written → READY next edge. ready=0 throughout.
- READY: flush=1 → CLEAR, clr_idx=0, busy bits cleared on same edge; flush in CLEAR restarts from index 0.
- While ready=0: we, iss_v ignored; rd1/rd2 = 0, bsy1/bsy2 = 0.
- Write: we && wa!=0 → state[wa]=wd at edge, and busy[wa] cleared.
- Issue: iss_v && iss_a!=0 → busy[iss_a] set at edge.
- Same-cycle we and iss_v to same address: issue wins, busy stays 1 (new producer), data still written.
- Address 0: writes and issues ignored; rd=0 and bsy=0 for ra=0 always.
- Reads combinational from array and scoreboard.

## Timing
- Reset values: ready=0, rd1=rd2=0, bsy1=bsy2=0; clr_idx=0.
- Clear latency: exactly DEPTH cycles from first edge after reset release (or flush edge) to ready=1.
- Write → visible on read port: next cycle (0 cycles with bypass, see Configuration).
- Issue → bsy visible: next cycle.
- Reset asserted mid-clear or mid-operation: immediate return to CLEAR, contents treated as undefined until clear completes.

## Configuration
- REGFILE_BYPASS_EN defined: if we && wa!=0 && ra==wa in READY, rd = wd and bsy = 0 combinationally in the same cycle (unless iss_v to the same address, then bsy=1).
- Undefined: rd and bsy reflect registered state only; write visible one cycle later.

## Structure
- Package regfile_pkg: FSM state typedef (CLEAR, READY), default DATA_W/ADDR_W constants.
- Sub-module regfile_scoreboard: DEPTH busy bits with set/clear/flush and two read ports; top holds array, clear FSM, bypass muxes.

## Test plan
- Reset release, DEPTH=32 → ready rises on cycle 32 exactly; all reads return 0 in between and after.
- we=1 wa=5 wd=0xDEADBEEF, ra1=5 → rd1=0xDEADBEEF next cycle; same cycle too with REGFILE_BYPASS_EN.
- we=1 wa=0 wd=0x1234, iss_v to 0 → rd1 for ra1=0 stays 0, bsy1=0.
- iss_v iss_a=7 → bsy1(ra1=7)=1 next cycle; we wa=7 later → bsy1=0 next cycle; same-cycle iss and we to 7 → bsy1 stays 1, data written.
- After writing 0xA5A5A5A5 to r3, flush → ready=0 for 32 cycles, then r3 reads 0 and all busy bits 0; writes during clear are dropped.
- rst_n pulsed low mid-clear at index 10 → clear restarts, ready after full 32 cycles from release.
